er_fetch: RTL and testbench

Earthrise command fetch unit: walks the Earthrise command list from a start address, reading through the list's read-only Earthrise port, and presents each command word to the Earthrise drawing core over a valid/ready stream. It sits between the command list memory and the command decoder. It hides the memory's fixed 2-cycle read latency with a credit-limited 4-entry buffer, so it sustains one command per cycle when the consumer is ready. It stops on a STOP word and signals completion to the system.

---
 rtl/er_fetch_if.sv | 23 ++
 rtl/er_fetch.sv | 173 +++++++++++++++++
 tb/tb_er_fetch.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/er_fetch_if.sv
// er_fetch_if: command stream between the fetch unit and the command decoder.
//
// Handshake: a word transfers on every rising clk edge where cmd_valid and
// cmd_ready are both high. Once cmd_valid is raised, the producer holds it and
// cmd_data steady until the transfer happens. cmd_ready may change freely and
// does not depend on cmd_valid.
//
// Signals:
//   cmd_valid  producer -> consumer  cmd_data holds a command
//   cmd_ready  consumer -> producer  consumer accepts the word this cycle
//   cmd_data   producer -> consumer  command word (WORD bits)
//
// Modports: master = producer (er_fetch), slave = consumer (decoder).
interface er_fetch_if #(
  parameter int WORD = 32
) ();
  logic            cmd_valid;
  logic            cmd_ready;
  logic [WORD-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_data, output cmd_ready);
endinterface

// File: rtl/er_fetch.sv
// er_fetch: Earthrise command fetch unit.
//
// Walks the command list from start_addr through a read-only port with a
// fixed 2-cycle read latency, and streams each command word to the drawing
// core. A 4-entry fall-through buffer plus credit accounting keeps one word
// per cycle flowing without ever overflowing. A STOP word (opcode 4'h0) ends
// the walk; done pulses once the buffer has drained.
//
// Optional feature macro: ERFETCH_JUMP_EN
//   defined   -> opcode 4'hE is a JUMP: consumed, pc <= low ADDRW bits.
//   undefined -> opcode 4'hE is an ordinary command and is delivered.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         start pulse (ignored while busy), start_addr sampled with it
//   abort         flush everything and return to IDLE (highest priority)
//   busy          high while a fetch is in progress
//   done          one-cycle pulse when the fetch completed normally
//   addr_er       registered list read address
//   dout_er       list read data, valid 2 cycles after addr_er
//   cmd           command stream (er_fetch_if.master)
//   state_dbg     current FSM state (IDLE=0, FETCH=1, DRAIN=2)
//   credit_dbg    words buffered plus reads in flight (never above 4)
module er_fetch #(
  parameter int WORD  = 32,
  parameter int ADDRW = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] start_addr,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] addr_er,
  input  logic [WORD-1:0]  dout_er,
  er_fetch_if.master       cmd,
  output logic [1:0]       state_dbg,
  output logic [2:0]       credit_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] OP_STOP = 4'h0;
`ifdef ERFETCH_JUMP_EN
  localparam logic [3:0] OP_JUMP = 4'hE;
`endif

  state_t           state;
  logic [ADDRW-1:0] pc;
  // addr_v: addr_er carries a live read this cycle.
  // rd_v:   return shift; rd_v[1] means dout_er holds live data now.
  logic             addr_v;
  logic [1:0]       rd_v;

  logic [WORD-1:0]  fifo_mem [4];
  logic [1:0]       wr_ptr;
  logic [1:0]       rd_ptr;
  logic [2:0]       count;
  logic [2:0]       count_next;
  logic [2:0]       occupancy;
  logic [2:0]       occ_after;

  logic [3:0]       opcode;
  logic             stop_hit;
  logic             jump_hit;
  logic             push;
  logic             pop;
  logic             issue;

  assign cmd.cmd_valid = (count != 3'd0);
  assign cmd.cmd_data  = (count != 3'd0) ? fifo_mem[rd_ptr] : '0;
  assign busy          = (state != IDLE);
  assign state_dbg     = state;
  assign credit_dbg    = occupancy;

  always_comb begin
    opcode   = dout_er[WORD-1 -: 4];
    stop_hit = rd_v[1] && (opcode == OP_STOP);
`ifdef ERFETCH_JUMP_EN
    jump_hit = rd_v[1] && (opcode == OP_JUMP);
`else
    jump_hit = 1'b0;
`endif
    push       = rd_v[1] && !stop_hit && !jump_hit;
    pop        = cmd.cmd_valid && cmd.cmd_ready;
    count_next = count + {2'b00, push} - {2'b00, pop};
    occupancy  = count + {2'b00, addr_v} + {2'b00, rd_v[0]} + {2'b00, rd_v[1]};
    // Credit is judged on next cycle's occupancy: a pop this cycle frees a
    // slot in time, which is what lets the loop sustain one word per cycle.
    // A pop implies count >= 1, so the subtraction cannot underflow.
    occ_after  = occupancy - {2'b00, pop};
    issue      = (state == FETCH) && !stop_hit && !jump_hit && (occ_after < 3'd4);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= dout_er;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc      <= '0;
      addr_er <= '0;
      addr_v  <= 1'b0;
      rd_v    <= 2'b00;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
      done    <= 1'b0;
    end else if (abort) begin
      state   <= IDLE;
      addr_v  <= 1'b0;
      rd_v    <= 2'b00;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      count   <= 3'd0;
      done    <= 1'b0;
    end else begin
      done   <= 1'b0;
      addr_v <= 1'b0;
      rd_v   <= {rd_v[0], addr_v};
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count_next;

      case (state)
        IDLE: begin
          if (start) begin
            // The first read goes out on the start edge itself.
            addr_er <= start_addr;
            pc      <= start_addr + ADDRW'(1);
            addr_v  <= 1'b1;
            state   <= FETCH;
          end
        end
        FETCH: begin
          if (stop_hit) begin
            // Everything fetched past STOP is dropped.
            addr_v <= 1'b0;
            rd_v   <= 2'b00;
            if (count_next == 3'd0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else if (jump_hit) begin
            addr_v <= 1'b0;
            rd_v   <= 2'b00;
            pc     <= dout_er[ADDRW-1:0];
          end else if (issue) begin
            addr_er <= pc;
            pc      <= pc + ADDRW'(1);
            addr_v  <= 1'b1;
          end
        end
        DRAIN: begin
          if (count_next == 3'd0) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_er_fetch.sv
// tb_er_fetch: self-checking bench for er_fetch with a 2-cycle list memory.
module tb_er_fetch;
  localparam int WORD  = 32;
  localparam int ADDRW = 9;

  localparam logic [WORD-1:0] W_A    = 32'h1000_00A1;
  localparam logic [WORD-1:0] W_B    = 32'h2000_00B2;
  localparam logic [WORD-1:0] W_C    = 32'h3000_00C3;
  localparam logic [WORD-1:0] W_X    = 32'h4000_01FE;
  localparam logic [WORD-1:0] W_Y    = 32'h4000_01FF;
  localparam logic [WORD-1:0] W_Z    = 32'h4000_0000;
  localparam logic [WORD-1:0] W_F0   = 32'h8000_0050;
  localparam logic [WORD-1:0] W_F1   = 32'h8000_0051;
  localparam logic [WORD-1:0] W_J0   = 32'h1111_0020;
  localparam logic [WORD-1:0] W_JMP  = 32'hE000_0080;
  localparam logic [WORD-1:0] W_JUNK = 32'h6666_0022;
  localparam logic [WORD-1:0] W_D    = 32'h2222_0080;
  localparam logic [WORD-1:0] W_STOP = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [ADDRW-1:0] start_addr;
  logic             abort;
  logic             busy;
  logic             done;
  logic [ADDRW-1:0] addr_er;
  logic [WORD-1:0]  dout_er;
  logic [1:0]       state_dbg;
  logic [2:0]       credit_dbg;

  er_fetch_if #(.WORD(WORD)) cmd_if ();

  er_fetch #(.WORD(WORD), .ADDRW(ADDRW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .addr_er    (addr_er),
    .dout_er    (dout_er),
    .cmd        (cmd_if),
    .state_dbg  (state_dbg),
    .credit_dbg (credit_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // List memory: data for addr_er in cycle A appears on dout_er in cycle A+2.
  logic [WORD-1:0] list_mem [512];
  logic [WORD-1:0] rd_pipe;
  always @(posedge clk) begin
    rd_pipe <= list_mem[addr_er];
    dout_er <= rd_pipe;
  end

  logic [WORD-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [ADDRW-1:0] a);
    start      = 1'b1;
    start_addr = a;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; start_addr = '0;
    cmd_if.cmd_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    if (cmd_if.cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", cmd_if.cmd_valid); end
    if (addr_er !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", addr_er); end
    if (cmd_if.cmd_data !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", cmd_if.cmd_data); end
  endtask

  // List {A,B,C,STOP} at 0x010, consumer always ready.
  task automatic test_basic();
    logic [WORD-1:0] exp_w;
    int n_del = 0;
    int done_cnt = 0;
    int done_k = 0;
    exp_q.delete();
    exp_q.push_back(W_A); exp_q.push_back(W_B); exp_q.push_back(W_C);
    cmd_if.cmd_ready = 1'b1;
    drive_start(9'h010);
    for (int k = 1; k <= 14; k++) begin
      if (k == 1) begin
        total += 2;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
        if (addr_er !== 9'h010) begin bad++; $display("FAIL basic_addr got=%h want=010", addr_er); end
      end
      if (done === 1'b1) begin done_cnt++; done_k = k; end
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL basic_extra got=%h want=none", cmd_if.cmd_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (cmd_if.cmd_data !== exp_w) begin bad++; $display("FAIL basic_data got=%h want=%h", cmd_if.cmd_data, exp_w); end
          total++;
          if (k != 4 + n_del) begin bad++; $display("FAIL basic_latency got=T+%0d want=T+%0d", k, 4 + n_del); end
        end
        n_del++;
      end
      tick();
    end
    total += 4;
    if (exp_q.size() != 0) begin bad++; $display("FAIL basic_missing got=%0d want=0", exp_q.size()); end
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt got=%0d want=1", done_cnt); end
    if (done_k != 7) begin bad++; $display("FAIL basic_done_time got=T+%0d want=T+7", done_k); end
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b want=0", busy); end
  endtask

  // Same list, cmd_ready pattern 1,0,0 repeating.
  task automatic test_backpressure();
    logic [WORD-1:0] exp_w;
    logic [WORD-1:0] held;
    logic stalled = 1'b0;
    int done_cnt = 0;
    exp_q.delete();
    exp_q.push_back(W_A); exp_q.push_back(W_B); exp_q.push_back(W_C);
    cmd_if.cmd_ready = 1'b0;
    drive_start(9'h010);
    for (int k = 1; k <= 40; k++) begin
      cmd_if.cmd_ready = (k % 3 == 1);
      total++;
      if (credit_dbg > 3'd4) begin bad++; $display("FAIL bp_credit got=%0d want<=4", credit_dbg); end
      if (stalled) begin
        total++;
        if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_data !== held) begin
          bad++; $display("FAIL bp_hold got=%b/%h want=1/%h", cmd_if.cmd_valid, cmd_if.cmd_data, held);
        end
      end
      if (done === 1'b1) done_cnt++;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL bp_extra got=%h want=none", cmd_if.cmd_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (cmd_if.cmd_data !== exp_w) begin bad++; $display("FAIL bp_data got=%h want=%h", cmd_if.cmd_data, exp_w); end
        end
      end
      stalled = cmd_if.cmd_valid && !cmd_if.cmd_ready;
      held    = cmd_if.cmd_data;
      tick();
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL bp_missing got=%0d want=0", exp_q.size()); end
    if (done_cnt != 1) begin bad++; $display("FAIL bp_done_cnt got=%0d want=1", done_cnt); end
  endtask

  // Address wrap 0x1FF -> 0x000.
  task automatic test_wrap();
    logic [WORD-1:0] exp_w;
    int done_cnt = 0;
    exp_q.delete();
    exp_q.push_back(W_X); exp_q.push_back(W_Y); exp_q.push_back(W_Z);
    cmd_if.cmd_ready = 1'b1;
    drive_start(9'h1FE);
    for (int k = 1; k <= 14; k++) begin
      if (k == 2) begin
        total++;
        if (addr_er !== 9'h1FF) begin bad++; $display("FAIL wrap_addr1 got=%h want=1ff", addr_er); end
      end
      if (k == 3) begin
        total++;
        if (addr_er !== 9'h000) begin bad++; $display("FAIL wrap_addr2 got=%h want=000", addr_er); end
      end
      if (done === 1'b1) done_cnt++;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL wrap_extra got=%h want=none", cmd_if.cmd_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (cmd_if.cmd_data !== exp_w) begin bad++; $display("FAIL wrap_data got=%h want=%h", cmd_if.cmd_data, exp_w); end
        end
      end
      tick();
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_missing got=%0d want=0", exp_q.size()); end
    if (done_cnt != 1) begin bad++; $display("FAIL wrap_done_cnt got=%0d want=1", done_cnt); end
  endtask

  // Abort with 3 words buffered and 1 in flight, then a fresh fetch.
  task automatic test_abort();
    logic [WORD-1:0] exp_w;
    int done_cnt = 0;
    cmd_if.cmd_ready = 1'b0;
    drive_start(9'h040);
    for (int k = 1; k <= 5; k++) tick();
    total += 2;
    if (cmd_if.cmd_valid !== 1'b1) begin bad++; $display("FAIL abort_pre_valid got=%b want=1", cmd_if.cmd_valid); end
    if (credit_dbg !== 3'd4) begin bad++; $display("FAIL abort_pre_credit got=%0d want=4", credit_dbg); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total += 3;
    if (cmd_if.cmd_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", cmd_if.cmd_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
    for (int k = 0; k < 5; k++) begin
      total++;
      if (done !== 1'b0 || cmd_if.cmd_valid !== 1'b0) begin
        bad++; $display("FAIL abort_quiet got=%b/%b want=0/0", done, cmd_if.cmd_valid);
      end
      tick();
    end
    // start and abort together while IDLE: stays IDLE
    start = 1'b1; abort = 1'b1; start_addr = 9'h050;
    tick();
    start = 1'b0; abort = 1'b0;
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_busy got=%b want=0", busy); end
    tick();
    exp_q.delete();
    exp_q.push_back(W_F0); exp_q.push_back(W_F1);
    cmd_if.cmd_ready = 1'b1;
    drive_start(9'h050);
    for (int k = 1; k <= 14; k++) begin
      if (done === 1'b1) done_cnt++;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL abort_fresh_extra got=%h want=none", cmd_if.cmd_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (cmd_if.cmd_data !== exp_w) begin bad++; $display("FAIL abort_fresh_data got=%h want=%h", cmd_if.cmd_data, exp_w); end
        end
      end
      tick();
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL abort_fresh_missing got=%0d want=0", exp_q.size()); end
    if (done_cnt != 1) begin bad++; $display("FAIL abort_fresh_done got=%0d want=1", done_cnt); end
  endtask

  // JUMP handling depends on the build configuration.
  task automatic test_jump();
    logic [WORD-1:0] exp_w;
    int done_cnt = 0;
    exp_q.delete();
    exp_q.push_back(W_J0);
`ifdef ERFETCH_JUMP_EN
    exp_q.push_back(W_D);
`else
    exp_q.push_back(W_JMP); exp_q.push_back(W_JUNK);
`endif
    cmd_if.cmd_ready = 1'b1;
    drive_start(9'h020);
    for (int k = 1; k <= 20; k++) begin
      if (done === 1'b1) done_cnt++;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL jump_extra got=%h want=none", cmd_if.cmd_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (cmd_if.cmd_data !== exp_w) begin bad++; $display("FAIL jump_data got=%h want=%h", cmd_if.cmd_data, exp_w); end
        end
      end
      tick();
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL jump_missing got=%0d want=0", exp_q.size()); end
    if (done_cnt != 1) begin bad++; $display("FAIL jump_done_cnt got=%0d want=1", done_cnt); end
  endtask

  // Reset in the middle of FETCH, then a normal fetch 3 cycles later.
  task automatic test_reset_mid();
    logic [WORD-1:0] exp_w;
    int done_cnt = 0;
    cmd_if.cmd_ready = 1'b1;
    drive_start(9'h040);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (done !== 1'b0) begin bad++; $display("FAIL rmid_done got=%b want=0", done); end
    if (cmd_if.cmd_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", cmd_if.cmd_valid); end
    if (addr_er !== '0) begin bad++; $display("FAIL rmid_addr got=%h want=0", addr_er); end
    if (cmd_if.cmd_data !== '0) begin bad++; $display("FAIL rmid_data got=%h want=0", cmd_if.cmd_data); end
    tick(); tick();
    exp_q.delete();
    exp_q.push_back(W_A); exp_q.push_back(W_B); exp_q.push_back(W_C);
    drive_start(9'h010);
    for (int k = 1; k <= 14; k++) begin
      if (done === 1'b1) done_cnt++;
      if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rmid_extra got=%h want=none", cmd_if.cmd_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (cmd_if.cmd_data !== exp_w) begin bad++; $display("FAIL rmid_fetch_data got=%h want=%h", cmd_if.cmd_data, exp_w); end
        end
      end
      tick();
    end
    total += 2;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rmid_missing got=%0d want=0", exp_q.size()); end
    if (done_cnt != 1) begin bad++; $display("FAIL rmid_done_cnt got=%0d want=1", done_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) list_mem[i] = 32'h5000_0000 | i;
    list_mem[9'h010] = W_A;   list_mem[9'h011] = W_B;
    list_mem[9'h012] = W_C;   list_mem[9'h013] = W_STOP;
    list_mem[9'h1FE] = W_X;   list_mem[9'h1FF] = W_Y;
    list_mem[9'h000] = W_Z;   list_mem[9'h001] = W_STOP;
    list_mem[9'h050] = W_F0;  list_mem[9'h051] = W_F1;
    list_mem[9'h052] = W_STOP;
    list_mem[9'h020] = W_J0;  list_mem[9'h021] = W_JMP;
    list_mem[9'h022] = W_JUNK; list_mem[9'h023] = W_STOP;
    list_mem[9'h080] = W_D;   list_mem[9'h081] = W_STOP;

    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_abort();
    test_jump();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
